// File: rtl/fft_post_pkg.sv
// Shared types and helpers for the FFT post-processing stage (power + peak).
package fft_post_pkg;

  localparam int DEF_FFT_SIZE   = 1024;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SKIP_DC    = 1;
  localparam int DEF_PWR_WIDTH  = 2 * DEF_DATA_WIDTH;
  localparam int DEF_BIN_WIDTH  = $clog2(DEF_FFT_SIZE);

  // One complex FFT bin as it arrives on the input bus: {re, im}.
  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } complex_t;

  // One beat of the power output stream.
  typedef struct packed {
    logic [DEF_PWR_WIDTH-1:0] pwr;
    logic [DEF_BIN_WIDTH-1:0] bin;
    logic                     last;
  } pwr_beat_t;

  // Squared magnitude re^2 + im^2. Each square is at most 2^(2DW-2), so the
  // sum (at most 2^(2DW-1)) always fits in 2*DW unsigned bits.
  function automatic logic [DEF_PWR_WIDTH-1:0] sq_mag(input complex_t c);
    logic signed [DEF_PWR_WIDTH-1:0] re_e;
    logic signed [DEF_PWR_WIDTH-1:0] im_e;
    logic        [DEF_PWR_WIDTH-1:0] re_sq;
    logic        [DEF_PWR_WIDTH-1:0] im_sq;
    re_e  = DEF_PWR_WIDTH'(c.re);
    im_e  = DEF_PWR_WIDTH'(c.im);
    re_sq = unsigned'(re_e * re_e);
    im_sq = unsigned'(im_e * im_e);
    return re_sq + im_sq;
  endfunction

endpackage

// File: rtl/fft_elastic_reg.sv
// Single valid/ready pipeline register. Loads whenever it is empty or its
// current contents are being taken downstream, so it runs at full rate and
// never inserts bubbles.
module fft_elastic_reg #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load_en;

  // Upstream may push when this stage is empty or is draining this cycle.
  assign w_load_en = !r_valid || i_ready;
  assign o_ready   = w_load_en;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  // Stage occupancy and payload; payload only changes on a real load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
    end else if (w_load_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end else begin
        r_data <= r_data;
      end
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

endmodule

// File: rtl/fft_power_peak.sv
// FFT bin post-processing: two-stage |X[k]|^2 pipeline with bin/last tags,
// plus a per-frame peak tracker that pulses its result after the last bin.
module fft_power_peak
  import fft_post_pkg::*;
#(
  parameter int FFT_SIZE   = DEF_FFT_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SKIP_DC    = DEF_SKIP_DC
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          fft_in_valid_i,
  input  logic [2*DATA_WIDTH-1:0]       fft_in_data_i,
  output logic                          fft_in_ready_o,
  output logic                          pwr_valid_o,
  output logic [2*DATA_WIDTH-1:0]       pwr_data_o,
  output logic [$clog2(FFT_SIZE)-1:0]   pwr_bin_o,
  output logic                          pwr_last_o,
  input  logic                          pwr_ready_i,
  output logic                          peak_valid_o,
  output logic [$clog2(FFT_SIZE)-1:0]   peak_bin_o,
  output logic [2*DATA_WIDTH-1:0]       peak_pwr_o
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int BW  = $clog2(FFT_SIZE);
  localparam int S1W = 2 * PW + BW + 1;
  localparam int S2W = PW + BW + 1;
  localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_SIZE - 1);
  // Restart value of the tracker: the first bin allowed to win a frame, so an
  // all-zero frame reports that bin.
  localparam logic [BW-1:0] FIRST_BIN = (SKIP_DC != 0) ? BW'(1) : BW'(0);

  // ---------------- input side: squares and bin tagging ----------------
  logic signed [DATA_WIDTH-1:0] w_re;
  logic signed [DATA_WIDTH-1:0] w_im;
  logic signed [PW-1:0]         w_re_ext;
  logic signed [PW-1:0]         w_im_ext;
  logic        [PW-1:0]         w_re_sq;
  logic        [PW-1:0]         w_im_sq;
  logic                         w_in_accept;
  logic [S1W-1:0]               w_s1_in;
  logic [BW-1:0]                r_bin_cnt;

  assign w_re     = $signed(fft_in_data_i[2*DATA_WIDTH-1:DATA_WIDTH]);
  assign w_im     = $signed(fft_in_data_i[DATA_WIDTH-1:0]);
  assign w_re_ext = PW'(w_re);
  assign w_im_ext = PW'(w_im);
  // Squares are non-negative and below 2^(PW-1), so reading them unsigned is exact.
  assign w_re_sq  = unsigned'(w_re_ext * w_re_ext);
  assign w_im_sq  = unsigned'(w_im_ext * w_im_ext);

  assign w_in_accept = fft_in_valid_i && fft_in_ready_o;
  assign w_s1_in     = {w_re_sq, w_im_sq, r_bin_cnt, (r_bin_cnt == LAST_BIN)};

  // Bin counter: one step per accepted input beat, wrapping at the frame end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bin_cnt <= {BW{1'b0}};
    end else if (w_in_accept) begin
      if (r_bin_cnt == LAST_BIN) begin
        r_bin_cnt <= {BW{1'b0}};
      end else begin
        r_bin_cnt <= r_bin_cnt + BW'(1);
      end
    end else begin
      r_bin_cnt <= r_bin_cnt;
    end
  end

  // ---------------- S1: registered squares ----------------
  logic           w_s1_valid;
  logic [S1W-1:0] w_s1_data;
  logic           w_s2_ready;
  logic [PW-1:0]  w_s1_re_sq;
  logic [PW-1:0]  w_s1_im_sq;
  logic [BW-1:0]  w_s1_bin;
  logic           w_s1_last;
  logic [PW-1:0]  w_sum;
  logic [S2W-1:0] w_s2_in;
  logic [S2W-1:0] w_s2_data;

  fft_elastic_reg #(.WIDTH(S1W)) u_s1 (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_valid (fft_in_valid_i),
    .i_data  (w_s1_in),
    .o_ready (fft_in_ready_o),
    .o_valid (w_s1_valid),
    .o_data  (w_s1_data),
    .i_ready (w_s2_ready)
  );

  assign {w_s1_re_sq, w_s1_im_sq, w_s1_bin, w_s1_last} = w_s1_data;
  // Cannot overflow: the largest possible sum is exactly 2^(PW-1).
  assign w_sum   = w_s1_re_sq + w_s1_im_sq;
  assign w_s2_in = {w_sum, w_s1_bin, w_s1_last};

  // ---------------- S2: registered sum, drives the output port ----------------
  fft_elastic_reg #(.WIDTH(S2W)) u_s2 (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_valid (w_s1_valid),
    .i_data  (w_s2_in),
    .o_ready (w_s2_ready),
    .o_valid (pwr_valid_o),
    .o_data  (w_s2_data),
    .i_ready (pwr_ready_i)
  );

  assign {pwr_data_o, pwr_bin_o, pwr_last_o} = w_s2_data;

  // ---------------- peak tracker ----------------
  logic          w_out_accept;
  logic          w_eligible;
  logic [PW-1:0] w_cand_pwr;
  logic [BW-1:0] w_cand_bin;
  logic [PW-1:0] r_max_pwr;
  logic [BW-1:0] r_max_bin;
  logic          r_peak_valid;
  logic [BW-1:0] r_peak_bin;
  logic [PW-1:0] r_peak_pwr;

  assign w_out_accept = pwr_valid_o && pwr_ready_i;
  assign w_eligible   = (SKIP_DC == 0) || (pwr_bin_o != {BW{1'b0}});

  // Running maximum including the beat being accepted now; strict compare keeps the lowest bin on ties.
  always_comb begin
    w_cand_pwr = r_max_pwr;
    w_cand_bin = r_max_bin;
    if (w_out_accept && w_eligible && (pwr_data_o > r_max_pwr)) begin
      w_cand_pwr = pwr_data_o;
      w_cand_bin = pwr_bin_o;
    end else begin
      w_cand_pwr = r_max_pwr;
      w_cand_bin = r_max_bin;
    end
  end

  // Tracker state and frame-end result; the result registers hold until the next frame end.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_max_pwr    <= {PW{1'b0}};
      r_max_bin    <= FIRST_BIN;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= {BW{1'b0}};
      r_peak_pwr   <= {PW{1'b0}};
    end else if (w_out_accept && pwr_last_o) begin
      r_peak_valid <= 1'b1;
      r_peak_bin   <= w_cand_bin;
      r_peak_pwr   <= w_cand_pwr;
      r_max_pwr    <= {PW{1'b0}};
      r_max_bin    <= FIRST_BIN;
    end else begin
      r_peak_valid <= 1'b0;
      r_peak_bin   <= r_peak_bin;
      r_peak_pwr   <= r_peak_pwr;
      r_max_pwr    <= w_cand_pwr;
      r_max_bin    <= w_cand_bin;
    end
  end

  assign peak_valid_o = r_peak_valid;
  assign peak_bin_o   = r_peak_bin;
  assign peak_pwr_o   = r_peak_pwr;

endmodule

// File: tb/tb_fft_power_peak.sv
// Self-checking bench for fft_power_peak (FFT_SIZE=8, DW=16). Two instances
// share all inputs: one with SKIP_DC=1, one with SKIP_DC=0.
module tb_fft_power_peak;

  localparam int N = 8;

  logic        clk;
  logic        rst_ni;
  logic        fft_in_valid;
  logic [31:0] fft_in_data;
  logic        pwr_ready;

  logic        w1_in_ready, w1_pwr_valid, w1_pwr_last, w1_peak_valid;
  logic [31:0] w1_pwr_data, w1_peak_pwr;
  logic [2:0]  w1_pwr_bin, w1_peak_bin;
  logic        w0_in_ready, w0_pwr_valid, w0_pwr_last, w0_peak_valid;
  logic [31:0] w0_pwr_data, w0_peak_pwr;
  logic [2:0]  w0_pwr_bin, w0_peak_bin;

  fft_power_peak #(.FFT_SIZE(N), .DATA_WIDTH(16), .SKIP_DC(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni),
    .fft_in_valid_i(fft_in_valid), .fft_in_data_i(fft_in_data), .fft_in_ready_o(w1_in_ready),
    .pwr_valid_o(w1_pwr_valid), .pwr_data_o(w1_pwr_data), .pwr_bin_o(w1_pwr_bin),
    .pwr_last_o(w1_pwr_last), .pwr_ready_i(pwr_ready),
    .peak_valid_o(w1_peak_valid), .peak_bin_o(w1_peak_bin), .peak_pwr_o(w1_peak_pwr)
  );

  fft_power_peak #(.FFT_SIZE(N), .DATA_WIDTH(16), .SKIP_DC(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni),
    .fft_in_valid_i(fft_in_valid), .fft_in_data_i(fft_in_data), .fft_in_ready_o(w0_in_ready),
    .pwr_valid_o(w0_pwr_valid), .pwr_data_o(w0_pwr_data), .pwr_bin_o(w0_pwr_bin),
    .pwr_last_o(w0_pwr_last), .pwr_ready_i(pwr_ready),
    .peak_valid_o(w0_peak_valid), .peak_bin_o(w0_peak_bin), .peak_pwr_o(w0_peak_pwr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pwr;
    int          bin;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frame_pwr[$];
  int          m_bin = 0;
  int          cyc = 0;
  bit          pend = 0;
  bit          lat_chk = 0;
  int          pulses = 0;
  logic [31:0] e1_pwr = 0, e0_pwr = 0, h1_pwr = 0, h0_pwr = 0;
  int          e1_bin = 0, e0_bin = 0, h1_bin = 0, h0_bin = 0;

  // Peak of a finished frame: first bin holding the largest power among the
  // bins from 'first' upward; defaults to 'first' with power 0.
  task automatic frame_peak(input int first, output int pbin, output logic [31:0] ppwr);
    pbin = first;
    ppwr = 32'd0;
    for (int i = first; i < frame_pwr.size(); i++) begin
      if (frame_pwr[i] > ppwr) begin
        ppwr = frame_pwr[i];
        pbin = i;
      end
    end
  endtask

  // Monitor: samples between clock edges, scores outputs, predicts peaks.
  always @(negedge clk) begin
    exp_t        e;
    longint      sr, si;
    cyc++;
    if (!rst_ni) begin
      exp_q.delete();
      frame_pwr.delete();
      m_bin = 0;
      pend  = 0;
      h1_bin = 0; h1_pwr = 32'd0; h0_bin = 0; h0_pwr = 32'd0;
    end else begin
      chk("in_ready_match", 64'(w0_in_ready), 64'(w1_in_ready));
      chk("peak_valid_skip1", 64'(w1_peak_valid), 64'(pend));
      chk("peak_valid_skip0", 64'(w0_peak_valid), 64'(pend));
      if (w1_peak_valid) pulses++;
      if (pend) begin
        h1_bin = e1_bin; h1_pwr = e1_pwr; h0_bin = e0_bin; h0_pwr = e0_pwr;
        pend = 0;
      end
      chk("peak_bin_skip1", 64'(w1_peak_bin), 64'(h1_bin));
      chk("peak_pwr_skip1", 64'(w1_peak_pwr), 64'(h1_pwr));
      chk("peak_bin_skip0", 64'(w0_peak_bin), 64'(h0_bin));
      chk("peak_pwr_skip0", 64'(w0_peak_pwr), 64'(h0_pwr));

      chk("pwr_valid_match", 64'(w0_pwr_valid), 64'(w1_pwr_valid));
      if (w1_pwr_valid && pwr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("pwr_data", 64'(w1_pwr_data), 64'(e.pwr));
          chk("pwr_bin", 64'(w1_pwr_bin), 64'(e.bin));
          chk("pwr_last", 64'(w1_pwr_last), 64'(e.last));
          chk("pwr_beat_skip0", {w0_pwr_data, 29'(w0_pwr_bin), w0_pwr_last},
              {e.pwr, 29'(e.bin), e.last});
          if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(2));
          frame_pwr.push_back(e.pwr);
          if (e.last) begin
            frame_peak(1, e1_bin, e1_pwr);
            frame_peak(0, e0_bin, e0_pwr);
            pend = 1;
            frame_pwr.delete();
          end
        end
      end

      if (fft_in_valid && w1_in_ready) begin
        sr = longint'($signed(fft_in_data[31:16]));
        si = longint'($signed(fft_in_data[15:0]));
        e.pwr  = 32'(sr * sr + si * si);
        e.bin  = m_bin;
        e.last = (m_bin == N - 1);
        e.cyc  = cyc;
        exp_q.push_back(e);
        m_bin = (m_bin + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_rdy = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) pwr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat(input logic [15:0] re, input logic [15:0] im);
    int n;
    bit acc;
    fft_in_valid = 1'b1;
    fft_in_data  = {re, im};
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = w1_in_ready;
      tick();
      n++;
    end
    if (!acc) chk("in_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    fft_in_valid = 1'b0;
    rand_rdy  = 0;
    pwr_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic random_frames(input int nf);
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < N; k++)
        drive_beat(16'($urandom), 16'($urandom));
  endtask

  int p0;

  initial begin
    rst_ni = 1'b0;
    fft_in_valid = 1'b0;
    fft_in_data = 32'd0;
    pwr_ready = 1'b1;
    repeat (3) tick();
    chk("rst_pwr_valid", 64'(w1_pwr_valid), 64'(0));
    chk("rst_pwr_data", 64'(w1_pwr_data), 64'(0));
    chk("rst_peak_valid", 64'(w1_peak_valid), 64'(0));
    chk("rst_peak", {w1_peak_pwr, 29'(w1_peak_bin), 3'd0}, 64'(0));
    rst_ni = 1'b1;
    tick();
    chk("idle_in_ready", 64'(w1_in_ready), 64'(1));

    // 1: ramp re=k, im=0, full rate, latency checked on every beat
    lat_chk = 1;
    for (int k = 0; k < N; k++) drive_beat(16'(k), 16'd0);
    drain();
    chk("t1_pulses", 64'(pulses), 64'(1));
    chk("t1_peak_bin_skip1", 64'(w1_peak_bin), 64'(7));
    chk("t1_peak_pwr_skip1", 64'(w1_peak_pwr), 64'(49));
    chk("t1_peak_bin_skip0", 64'(w0_peak_bin), 64'(7));

    // 2: full-scale negative corner on bin 3
    for (int k = 0; k < N; k++)
      if (k == 3) drive_beat(16'h8000, 16'h8000);
      else        drive_beat(16'd1, 16'd1);
    drain();
    chk("t2_peak_bin", 64'(w1_peak_bin), 64'(3));
    chk("t2_peak_pwr", 64'(w1_peak_pwr), 64'h8000_0000);

    // 4: ties and DC handling
    for (int k = 0; k < N; k++)
      if (k == 0)                drive_beat(16'd30, 16'd10);
      else if (k == 2 || k == 5) drive_beat(16'd10, 16'd0);
      else                       drive_beat(16'd0, 16'd0);
    drain();
    chk("t4_dc_bin_skip1", 64'(w1_peak_bin), 64'(2));
    chk("t4_dc_pwr_skip1", 64'(w1_peak_pwr), 64'(100));
    chk("t4_dc_bin_skip0", 64'(w0_peak_bin), 64'(0));
    chk("t4_dc_pwr_skip0", 64'(w0_peak_pwr), 64'(1000));
    for (int k = 0; k < N; k++)
      if (k == 2 || k == 5) drive_beat(16'd0, 16'hFFF6);
      else                  drive_beat(16'd0, 16'd0);
    drain();
    chk("t4_tie_bin_skip0", 64'(w0_peak_bin), 64'(2));
    chk("t4_tie_bin_skip1", 64'(w1_peak_bin), 64'(2));
    for (int k = 0; k < N; k++) drive_beat(16'd0, 16'd0);
    drain();
    chk("t4_zero_bin_skip1", 64'(w1_peak_bin), 64'(1));
    chk("t4_zero_bin_skip0", 64'(w0_peak_bin), 64'(0));
    chk("t4_zero_pwr_skip1", 64'(w1_peak_pwr), 64'(0));

    // 3: sustained stall backs up to the input, then random backpressure
    lat_chk = 0;
    pwr_ready = 1'b0;
    fft_in_valid = 1'b1;
    fft_in_data = {16'd3, 16'd4};
    repeat (2) tick();
    @(negedge clk);
    chk("t3_stall_in_ready", 64'(w1_in_ready), 64'(0));
    tick();
    pwr_ready = 1'b1;
    while (m_bin != 0) drive_beat(16'($urandom), 16'($urandom));
    drain();
    p0 = pulses;
    rand_rdy = 1;
    random_frames(3);
    drain();
    chk("t3_pulses", 64'(pulses - p0), 64'(3));

    // 5: back-to-back frames, no idle cycle
    lat_chk = 1;
    p0 = pulses;
    random_frames(2);
    drain();
    chk("t5_pulses", 64'(pulses - p0), 64'(2));

    // 6: reset in the middle of a frame
    lat_chk = 0;
    for (int k = 0; k < 3; k++) drive_beat(16'd50, 16'd50);
    fft_in_data = {16'd60, 16'd0};
    rst_ni = 1'b0;
    fft_in_valid = 1'b0;
    repeat (2) tick();
    chk("t6_rst_pwr_valid", 64'(w1_pwr_valid), 64'(0));
    chk("t6_rst_peak", {w1_peak_pwr, 29'(w1_peak_bin), 2'd0, w1_peak_valid}, 64'(0));
    rst_ni = 1'b1;
    tick();
    p0 = pulses;
    lat_chk = 1;
    random_frames(1);
    drain();
    chk("t6_pulses", 64'(pulses - p0), 64'(1));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
